// File: rtl/nx_mesh_sequencer_if.sv
// Control/mesh-facing bundle for the evaluation-cycle sequencer.
// master: host/mesh side that drives requests and idles; slave: the sequencer.
interface nx_mesh_sequencer_if #(
  parameter int unsigned COLUMNS     = 3,
  parameter int unsigned CYCLE_WIDTH = 24
);
  logic                   i_enable;
  logic                   i_step;
  logic                   i_clear;
  logic [CYCLE_WIDTH-1:0] i_limit;
  logic [COLUMNS-1:0]     i_node_idle;
  logic                   i_agg_idle;
  logic [COLUMNS-1:0]     o_trigger;
  logic                   o_active;
  logic                   o_done;
  logic [CYCLE_WIDTH-1:0] o_cycle;

  modport master (
    output i_enable, i_step, i_clear, i_limit, i_node_idle, i_agg_idle,
    input  o_trigger, o_active, o_done, o_cycle
  );

  modport slave (
    input  i_enable, i_step, i_clear, i_limit, i_node_idle, i_agg_idle,
    output o_trigger, o_active, o_done, o_cycle
  );
endinterface

// File: rtl/nx_mesh_sequencer.sv
// Evaluation-cycle sequencer: waits for the mesh to drain (settled idle), fires a one-cycle
// trigger to every column, blanks the stale registered idles, and counts issued triggers.
// Supports free-run, bounded-run (cycle limit) and single-step operation.
module nx_mesh_sequencer #(
  parameter int unsigned COLUMNS     = 3,
  parameter int unsigned CYCLE_WIDTH = 24,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned BLANK       = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  nx_mesh_sequencer_if.slave bus
);

  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned BlankW  = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
  localparam logic [BlankW-1:0]  BlankLast  = BlankW'(BLANK - 1);

  typedef enum logic [2:0] {
    StStopped,
    StWait,
    StTrigger,
    StBlank,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [SettleW-1:0]     settle_q, settle_d;
  logic [BlankW-1:0]      blank_q, blank_d;
  logic                   step_pending_q, step_pending_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;

  logic all_idle;
  logic limit_hit;

  assign all_idle  = (&bus.i_node_idle) & bus.i_agg_idle;
  assign limit_hit = (bus.i_limit != '0) && (cycle_q >= bus.i_limit);

  // Next-state and counter updates.
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    blank_d        = blank_q;
    step_pending_d = step_pending_q;
    cycle_d        = cycle_q;
    case (state_q)
      StStopped: begin
        settle_d = '0;
        if (bus.i_clear) cycle_d = '0;
        if (bus.i_step) step_pending_d = 1'b1;
        if (bus.i_enable || bus.i_step) state_d = StWait;
      end
      StWait: begin
        if (!all_idle) begin
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          settle_d = '0;
          if (limit_hit) begin
            state_d = StDone;
          end else if (!bus.i_enable && !step_pending_q) begin
            state_d = StStopped;
          end else begin
            state_d = StTrigger;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StTrigger: begin
        step_pending_d = 1'b0;
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
        blank_d = '0;
        state_d = StBlank;
      end
      StBlank: begin
        // Registered idles still reflect the pre-trigger mesh; ignore them here.
        if (blank_q == BlankLast) begin
          blank_d  = '0;
          settle_d = '0;
          state_d  = StWait;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      StDone: begin
        if (!bus.i_enable) state_d = StStopped;
      end
      default: state_d = StStopped;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StStopped;
      settle_q       <= '0;
      blank_q        <= '0;
      step_pending_q <= 1'b0;
      cycle_q        <= '0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      blank_q        <= blank_d;
      step_pending_q <= step_pending_d;
      cycle_q        <= cycle_d;
    end
  end

  // Outputs decode from state/registers only; no input-to-output path.
  assign bus.o_trigger = {COLUMNS{state_q == StTrigger}};
  assign bus.o_active  = (state_q == StWait) || (state_q == StTrigger) || (state_q == StBlank);
  assign bus.o_done    = (state_q == StDone);
  assign bus.o_cycle   = cycle_q;

endmodule
